// File: rtl/sensor_conditioner.sv
// ---------------------------------------------------------------------------
// sensor_conditioner
//
// Front end between the field sensor pins and the irrigation control core.
// Every raw input is brought into the clock domain by a two-flop
// synchronizer. Each input then has its own debounce filter. The three
// filtered water-level probes are also checked for a physically impossible
// pattern. A persistence-filtered fault flag reports that condition.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive mismatching cycles before a filtered value
//                     follows its synchronized input (2..65535)
//   FAULT_CYCLES    : consecutive invalid/valid level-pattern cycles before
//                     the fault sets/clears (1..65535)
//
// Ports
//   clock, reset                 : system clock, async active-high reset
//   *_raw (7)                    : raw probe, sensor and button pins
//   low/mid/high_water_level     : debounced level probes
//   earth/air_humidity,
//   low_temperature              : debounced environment sensors
//   selector                     : debounced mode button level
//   selector_pressed             : 1-cycle pulse on debounced button press
//   conflicting_values           : persistent level-probe inconsistency
//   sensor_update                : 1-cycle pulse when any of the six
//                                  debounced sensor outputs changes
// ---------------------------------------------------------------------------
module sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FAULT_CYCLES    = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic low_water_level_raw,
    input  logic mid_water_level_raw,
    input  logic high_water_level_raw,
    input  logic earth_humidity_raw,
    input  logic air_humidity_raw,
    input  logic low_temperature_raw,
    input  logic selector_raw,
    output logic low_water_level,
    output logic mid_water_level,
    output logic high_water_level,
    output logic earth_humidity,
    output logic air_humidity,
    output logic low_temperature,
    output logic selector,
    output logic selector_pressed,
    output logic conflicting_values,
    output logic sensor_update
);

    localparam int NCH = 7;
    localparam int SEL = 6;   // channel index of the selector button
    localparam int CW  = $clog2(DEBOUNCE_CYCLES);
    // A single-cycle fault filter still needs a one-bit counter vector.
    localparam int FW  = (FAULT_CYCLES > 1) ? $clog2(FAULT_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(FAULT_CYCLES - 1);

    // Channel order: 0 low, 1 mid, 2 high, 3 earth, 4 air, 5 low_temp, 6 selector
    logic [NCH-1:0] w_raw;
    logic [NCH-1:0] r_sync1;
    logic [NCH-1:0] r_sync2;
    logic [NCH-1:0] w_filt;
    logic [NCH-1:0] w_flip;

    assign w_raw = {selector_raw, low_temperature_raw, air_humidity_raw,
                    earth_humidity_raw, high_water_level_raw,
                    mid_water_level_raw, low_water_level_raw};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // -----------------------------------------------------------------------
    // Debounce channels
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            logic [CW-1:0] r_cnt;
            logic          r_filt;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_cnt  <= '0;
                    r_filt <= 1'b0;
                end else if (r_sync2[gi] == r_filt) begin
                    // Any return to the filtered value restarts the run.
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_filt <= r_sync2[gi];
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_filt[gi] = r_filt;
            // High at the edge where this channel's filtered value toggles.
            assign w_flip[gi] = (r_sync2[gi] != r_filt) && (r_cnt == CNT_LAST);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Change pulses, valid in the same cycle as the new filtered values
    // -----------------------------------------------------------------------
    logic r_sensor_update;
    logic r_selector_pressed;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sensor_update    <= 1'b0;
            r_selector_pressed <= 1'b0;
        end else begin
            r_sensor_update    <= |w_flip[SEL-1:0];
            r_selector_pressed <= w_flip[SEL] & ~w_filt[SEL];
        end
    end

    // -----------------------------------------------------------------------
    // Water-level consistency fault
    // -----------------------------------------------------------------------
    typedef enum logic {
        ST_OK    = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [FW-1:0] r_fcnt;
    logic [FW-1:0] w_fcnt_next;
    logic          w_invalid;
    logic          w_against;

    // Water above a probe with a dry probe beneath it cannot happen.
    assign w_invalid = (w_filt[2] & ~w_filt[1]) | (w_filt[1] & ~w_filt[0]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_OK;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_fcnt  <= w_fcnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fcnt_next  = r_fcnt;
        // The counter tracks evidence against the current state: invalid
        // cycles while OK, valid cycles while FAULT.
        w_against = (r_state == ST_OK) ? w_invalid : ~w_invalid;
        if (w_against) begin
            if (r_fcnt == FCNT_LAST) begin
                w_state_next = (r_state == ST_OK) ? ST_FAULT : ST_OK;
                w_fcnt_next  = '0;
            end else begin
                w_fcnt_next = r_fcnt + 1'b1;
            end
        end else begin
            w_fcnt_next = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign low_water_level    = w_filt[0];
    assign mid_water_level    = w_filt[1];
    assign high_water_level   = w_filt[2];
    assign earth_humidity     = w_filt[3];
    assign air_humidity       = w_filt[4];
    assign low_temperature    = w_filt[5];
    assign selector           = w_filt[SEL];
    assign selector_pressed   = r_selector_pressed;
    assign sensor_update      = r_sensor_update;
    assign conflicting_values = (r_state == ST_FAULT);

endmodule

// File: tb/tb_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// tb_sensor_conditioner
//
// The reference model treats each debounce channel as a sliding window. It
// holds the last D synchronized samples, and the filtered value flips when
// the whole window disagrees with it. The fault flag uses the same idea: a
// window of the last F validity flags. The bench compares the model against
// the DUT on every falling edge. Literal checks pin the D+2 and fault
// latencies and the pulse behaviour.
// ---------------------------------------------------------------------------
module tb_sensor_conditioner;

    localparam int D = 16;
    localparam int F = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] raw   = '0;

    logic low_water_level, mid_water_level, high_water_level;
    logic earth_humidity, air_humidity, low_temperature;
    logic selector, selector_pressed, conflicting_values, sensor_update;

    always #5 clock = ~clock;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .FAULT_CYCLES   (F)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .low_water_level_raw (raw[0]),
        .mid_water_level_raw (raw[1]),
        .high_water_level_raw(raw[2]),
        .earth_humidity_raw  (raw[3]),
        .air_humidity_raw    (raw[4]),
        .low_temperature_raw (raw[5]),
        .selector_raw        (raw[6]),
        .low_water_level     (low_water_level),
        .mid_water_level     (mid_water_level),
        .high_water_level    (high_water_level),
        .earth_humidity      (earth_humidity),
        .air_humidity        (air_humidity),
        .low_temperature     (low_temperature),
        .selector            (selector),
        .selector_pressed    (selector_pressed),
        .conflicting_values  (conflicting_values),
        .sensor_update       (sensor_update)
    );

    // ---------------- behavioural model ----------------
    bit [6:0]   m_s1 = '0, m_s2 = '0, m_filt = '0;
    bit [D-1:0] m_hist [7];
    bit [F-1:0] m_fhist = '0;
    bit         m_fault = 1'b0, m_upd = 1'b0, m_prs = 1'b0;

    int  n_vec = 0;
    int  n_err = 0;
    bit  done  = 1'b0;

    task automatic model_init();
        m_s1 = '0; m_s2 = '0; m_filt = '0;
        for (int c = 0; c < 7; c++) m_hist[c] = '0;
        m_fhist = '0; m_fault = 1'b0; m_upd = 1'b0; m_prs = 1'b0;
    endtask

    task automatic model_step();
        bit [6:0] old_filt;
        bit       inv;
        old_filt = m_filt;
        inv = (old_filt[2] & ~old_filt[1]) | (old_filt[1] & ~old_filt[0]);
        for (int c = 0; c < 7; c++) begin
            m_hist[c] = {m_hist[c][D-2:0], m_s2[c]};
            if (old_filt[c] ? (m_hist[c] == '0) : (m_hist[c] == '1))
                m_filt[c] = ~old_filt[c];
        end
        m_upd = (m_filt[5:0] != old_filt[5:0]);
        m_prs = m_filt[6] & ~old_filt[6];
        m_fhist = {m_fhist[F-2:0], inv};
        if (!m_fault && m_fhist == '1)      m_fault = 1'b1;
        else if (m_fault && m_fhist == '0)  m_fault = 1'b0;
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [9:0] dut_vec();
        return {selector_pressed, sensor_update, conflicting_values, selector,
                low_temperature, air_humidity, earth_humidity,
                high_water_level, mid_water_level, low_water_level};
    endfunction

    // ---------------- main ----------------
    initial begin
        for (int c = 0; c < 7; c++) m_hist[c] = '0;
        fork
            // model process
            begin
                while (!done) begin
                    @(posedge clock or posedge reset);
                    if (reset) model_init();
                    else       model_step();
                end
            end
            // per-cycle compare process
            begin
                while (!done) begin
                    @(negedge clock);
                    n_vec++;
                    if (dut_vec() !== {m_prs, m_upd, m_fault, m_filt}) begin
                        n_err++;
                        $display("FAIL cycle_cmp: got %b expected %b at %0t",
                                 dut_vec(), {m_prs, m_upd, m_fault, m_filt}, $time);
                    end
                end
            end
            // stimulus process
            begin
                int np, nu;
                repeat (3) tick();
                reset = 1'b0;
                chk("reset_state", int'(dut_vec()), 0);

                // low probe rises at edge 18 with a single update pulse
                raw[0] = 1'b1;
                for (int k = 1; k <= 20; k++) begin
                    tick();
                    chk("t1_low", int'(low_water_level), int'(k >= 18));
                    chk("t1_upd", int'(sensor_update), int'(k == 18));
                end

                // air humidity glitch restarts the count
                raw[4] = 1'b1;
                repeat (10) tick();
                chk("t2_air_early", int'(air_humidity), 0);
                raw[4] = 1'b0;
                tick();
                raw[4] = 1'b1;
                for (int k = 1; k <= 18; k++) begin
                    tick();
                    chk("t2_air", int'(air_humidity), int'(k == 18));
                end

                // conflicting probes: high without mid/low
                raw = '0;
                do_reset();
                raw = 7'b0000100;
                for (int k = 1; k <= 26; k++) begin
                    tick();
                    chk("t3_set", int'(conflicting_values), int'(k >= 26));
                end
                raw = 7'b0000111;
                for (int k = 1; k <= 26; k++) begin
                    tick();
                    chk("t3_clr", int'(conflicting_values), int'(k < 26));
                end

                // selector press: one pulse at press, none at release
                raw = '0;
                do_reset();
                raw[6] = 1'b1;
                np = 0; nu = 0;
                for (int k = 0; k < 100; k++) begin
                    if (k == 40) raw[6] = 1'b0;
                    tick();
                    np += int'(selector_pressed);
                    nu += int'(sensor_update);
                end
                chk("t4_pulses", np, 1);
                chk("t4_no_upd", nu, 0);

                // reset in the middle of an earth-humidity count
                raw = 7'b0000001;
                repeat (20) tick();
                chk("t5_low_pre", int'(low_water_level), 1);
                raw[3] = 1'b1;
                repeat (14) tick();
                reset = 1'b1;
                #1;
                chk("t5_async_zero", int'(dut_vec()), 0);
                tick();
                reset = 1'b0;
                for (int k = 1; k <= 18; k++) begin
                    tick();
                    chk("t5_earth", int'(earth_humidity), int'(k == 18));
                end

                // three channels change together -> one update pulse
                raw = '0;
                do_reset();
                raw = 7'b0101001;
                nu = 0;
                for (int k = 1; k <= 22; k++) begin
                    tick();
                    chk("t6_vals", int'({low_temperature, earth_humidity, low_water_level}),
                        (k >= 18) ? 7 : 0);
                    nu += int'(sensor_update);
                end
                chk("t6_one_pulse", nu, 1);

                // randomized phase, checked by the model every cycle
                for (int k = 0; k < 4000; k++) begin
                    for (int c = 0; c < 7; c++)
                        if ($urandom_range(0, 39) == 0) raw[c] = ~raw[c];
                    if ($urandom_range(0, 1499) == 0) do_reset();
                    else tick();
                end

                tick();
                done = 1'b1;
                tick();
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Front-end stage between the field sensor pins and the irrigation control logic. It synchronizes every raw sensor and button input to `clock` and debounces each one. It also validates the three water-level probes, producing a persistence-filtered `conflicting_values` fault. Its outputs directly drive the water-level, humidity, temperature and selector inputs of the top-level control core, in place of raw pins.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive cycles a synchronized input must differ from its filtered value before the filtered value follows; legal range 2..65535.
- `FAULT_CYCLES`, 8: consecutive cycles an invalid or valid level pattern must persist before `conflicting_values` sets or clears; legal range 1..65535.
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `low_water_level_raw`, `mid_water_level_raw`, `high_water_level_raw`  in  1 each  raw level probes; 1 = water present at probe.
- `earth_humidity_raw`, `air_humidity_raw`, `low_temperature_raw`  in  1 each  raw environment sensors.
- `selector_raw`  in  1  raw mode push-button.
- `low_water_level`, `mid_water_level`, `high_water_level`  out  1 each  debounced levels.
- `earth_humidity`, `air_humidity`, `low_temperature`  out  1 each  debounced environment signals.
- `selector`  out  1  debounced button level.
- `selector_pressed`  out  1  one-cycle pulse on the debounced selector 0->1 transition.
- `conflicting_values`  out  1  persistent water-probe inconsistency fault.
- `sensor_update`  out  1  one-cycle pulse when any of the six debounced sensor outputs changes; selector is excluded.

## Operation
- Each of the 7 inputs passes through a 2-flop synchronizer, `sync1` -> `sync2`, then its own debounce channel.
- Each debounce channel has a counter `cnt` of width clog2(`DEBOUNCE_CYCLES`) and a filtered register `filt`. At each edge:
  - if `sync2 == filt`: `cnt <= 0`.
  - else if `cnt == DEBOUNCE_CYCLES-1`: `filt <= sync2`, `cnt <= 0`.
  - else: `cnt <= cnt+1`.
  - Any glitch that returns `sync2` to `filt` restarts the count from 0.
- Invalid level pattern, evaluated on the filtered values: `(high & ~mid) | (mid & ~low)`. Any other pattern is valid.
- Fault FSM with states OK and FAULT, plus a persistence counter `fcnt`:
  - In OK: each invalid cycle increments `fcnt`; a valid cycle zeroes it. On the `FAULT_CYCLES`-th consecutive invalid cycle, go to FAULT and zero `fcnt`.
  - In FAULT: the behaviour mirrors OK, counting consecutive valid cycles, and returns to OK after `FAULT_CYCLES` of them.
  - `conflicting_values` = 1 exactly in FAULT; the output is registered.
- `sensor_update`: registered; equals 1 in the cycle after any edge at which any of the six sensor `filt` bits changed. It is therefore concurrent with the new values.
- `selector_pressed`: registered; equals 1 in the cycle after the edge at which selector `filt` went 0->1. No pulse on release.
- Channels are fully independent, and simultaneous changes on several channels are handled in parallel. Several channels updating at the same edge produce a single `sensor_update` pulse.

## Timing
- Reset (asynchronous, immediate): every synchronizer flop, `filt`, `cnt`, `fcnt` and pulse register goes to 0. State = OK. All outputs are 0, including every debounced level output.
- Debounce latency: a raw change held stable before edge 1 reaches `sync2` at edge 2. `filt` changes at edge 2+`DEBOUNCE_CYCLES`. With D = 16 this is edge 18, giving a total of D+2 cycles.
- Fault latency: `conflicting_values` sets at the `FAULT_CYCLES`-th edge after the first edge at which the filtered pattern is invalid. It clears with the same latency after the pattern becomes valid.
- Pulse width: `sensor_update` and `selector_pressed` are exactly 1 cycle wide. Back-to-back filtered changes on consecutive edges give pulses on consecutive cycles.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1` and never wraps. `fcnt` never exceeds `FAULT_CYCLES-1`.
- Reset asserted mid-count discards partial counts. After release, the debounce timing restarts from zero.

## Test plan
- Reset, then raise `low_water_level_raw` and hold it, with D = 16 -> `low_water_level` goes 1 at edge 18 and `sensor_update` is 1 for cycle 18 only. No earlier change occurs.
- Toggle `air_humidity_raw` to 1 for 10 cycles, 0 for 1 cycle, 1 onward -> no output change at 10 cycles; `air_humidity` rises 18 cycles after the final rise.
- Stable `high_raw` = 1 with `mid_raw` = `low_raw` = 0, F = 8 -> `conflicting_values` sets 8 edges after the filtered pattern becomes invalid. Raising `mid_raw` and `low_raw` clears it 8 edges after their filtered values settle.
- Press `selector_raw` for 40 cycles, then release -> `selector_pressed` gives exactly one 1-cycle pulse at debounced rise, none at release, and `sensor_update` stays 0.
- Assert `reset` for 1 cycle while `cnt` = 12 on `earth_humidity` -> all outputs read 0 immediately. After release, `earth_humidity` rises only after a full 18 cycles.
- Change `low_raw`, `earth_raw` and `low_temperature_raw` on the same edge -> all three filtered outputs change at the same edge and a single `sensor_update` pulse occurs.
